// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin arbiter that shares one uarttx
// transmitter among NUM_REQ byte-stream requesters.
// Optional feature macro: UART_ARB_TIMEOUT_EN. When it is defined, an owner
// that leaves its grant idle for TIMEOUT_CYCLES cycles in ISSUE is released.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int GRANT_W        = $clog2(NUM_REQ),
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_byte,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ack,
   output logic                 tx_start,
   output logic [7:0]           tx_byte,
   input  logic                 tx_ready,
   output logic                 grant_valid,
   output logic [GRANT_W-1:0]   grant_id
);

   localparam logic [1:0] S_ARB   = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_START = 2'd2;
   localparam logic [1:0] S_WAIT  = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [GRANT_W-1:0] grant_id_q, grant_id_d;
   logic               grant_valid_q, grant_valid_d;
   logic               tx_start_q, tx_start_d;
   logic [7:0]         tx_byte_q, tx_byte_d;
   logic               last_q, last_d;

   logic               found;
   logic [GRANT_W-1:0] winner;
   logic [GRANT_W:0]   idx;
   logic               accept;
   logic [7:0]         sel_byte;
   logic [GRANT_W-1:0] next_ptr;
   logic               to_fire;

   assign sel_byte = req_byte[8*grant_id_q +: 8];
   assign accept   = (state_q == S_ISSUE) && req_valid[grant_id_q] && tx_ready;
   assign next_ptr = (grant_id_q == GRANT_W'(NUM_REQ-1)) ? '0 : grant_id_q + 1'b1;

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, rr_ptr_q} + (GRANT_W+1)'(k);
         if (idx >= (GRANT_W+1)'(NUM_REQ)) idx = idx - (GRANT_W+1)'(NUM_REQ);
         if (!found && req_valid[idx[GRANT_W-1:0]]) begin
            found  = 1'b1;
            winner = idx[GRANT_W-1:0];
         end
      end
   end

   // Acknowledge is combinational and only ever for the current owner.
   always_comb begin
      req_ack = '0;
      if (accept) req_ack = NUM_REQ'(1) << grant_id_q;
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   // Idle-owner timer: counts ISSUE cycles without a byte, cleared on accept.
   always_comb begin
      to_cnt_d = to_cnt_q;
      to_fire  = 1'b0;
      if (state_q != S_ISSUE || accept) begin
         to_cnt_d = '0;
      end else if (!req_valid[grant_id_q]) begin
         if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            to_fire  = 1'b1;
            to_cnt_d = '0;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end
   end

   // Timer register.
   always_ff @(posedge clk) begin
      if (rst) to_cnt_q <= '0;
      else     to_cnt_q <= to_cnt_d;
   end
`else
   assign to_fire = 1'b0;
`endif

   // Arbitration / issue FSM next-state logic.
   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      grant_id_d    = grant_id_q;
      grant_valid_d = grant_valid_q;
      tx_start_d    = 1'b0;
      tx_byte_d     = tx_byte_q;
      last_d        = last_q;
      case (state_q)
         S_ARB: begin
            if (found) begin
               grant_id_d    = winner;
               grant_valid_d = 1'b1;
               state_d       = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (accept) begin
               tx_byte_d  = sel_byte;
               last_d     = req_last[grant_id_q];
               tx_start_d = 1'b1;
               state_d    = S_START;
            end else if (to_fire) begin
               // Timeout release behaves exactly like a finished packet.
               grant_valid_d = 1'b0;
               rr_ptr_d      = next_ptr;
               state_d       = S_ARB;
            end
         end
         S_START: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (tx_ready) begin
               if (last_q) begin
                  grant_valid_d = 1'b0;
                  rr_ptr_d      = next_ptr;
                  state_d       = S_ARB;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         default: state_d = S_ARB;
      endcase
   end

   // State registers; reset abandons any packet in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_ARB;
         rr_ptr_q      <= '0;
         grant_id_q    <= '0;
         grant_valid_q <= 1'b0;
         tx_start_q    <= 1'b0;
         tx_byte_q     <= '0;
         last_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_id_q    <= grant_id_d;
         grant_valid_q <= grant_valid_d;
         tx_start_q    <= tx_start_d;
         tx_byte_q     <= tx_byte_d;
         last_q        <= last_d;
      end
   end

   assign tx_start    = tx_start_q;
   assign tx_byte     = tx_byte_q;
   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;

endmodule
